// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
// Imported by the arbiter top and its timeout counter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   function automatic int cnt_w(int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic arb_state_t busy_of(logic own);
      return (own == OWNER_D) ? BUSY_D : BUSY_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified memory handshakes.
// master = arbiter view, slave = cpu/memory environment view.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          im_req;
   logic [AW-1:0] im_addr;
   logic          im_valid;
   logic [DW-1:0] im_data;
   logic          im_err;

   logic          dm_req;
   logic [AW-1:0] dm_addr;
   logic          dm_write;
   logic [DW-1:0] dm_wdata;
   logic          dm_valid;
   logic [DW-1:0] dm_rdata;
   logic          dm_err;

   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_write;
   logic [DW-1:0] mem_write_data;
   logic          mem_ack;
   logic [DW-1:0] mem_read_data;

   modport master (
      input  im_req, im_addr,
      input  dm_req, dm_addr, dm_write, dm_wdata,
      input  mem_ack, mem_read_data,
      output im_valid, im_data, im_err,
      output dm_valid, dm_rdata, dm_err,
      output mem_req, mem_addr, mem_write,
      output mem_write_data
   );

   modport slave (
      output im_req, im_addr,
      output dm_req, dm_addr, dm_write, dm_wdata,
      output mem_ack, mem_read_data,
      input  im_valid, im_data, im_err,
      input  dm_valid, dm_rdata, dm_err,
      input  mem_req, mem_addr, mem_write,
      input  mem_write_data
   );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Clearable busy-cycle counter; tc marks the last cycle a
// transaction may wait for mem_ack before it is failed.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = cnt_w(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   assign tc = en & (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports:
// data-first priority with a fetch anti-starvation streak limit.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT         = 16
) (
   input logic                 clk,
   input logic                 rst,
   mem_port_arbiter_if.master  bus
);

   localparam int SW = cnt_w(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

   arb_state_t    state;
   logic [SW-1:0] streak;
   logic          req_q;
   logic [AW-1:0] addr_q;
   logic          wr_q;
   logic [DW-1:0] wdata_q;

   logic tc;
   logic busy;
   logic done;
   logic grant;
   logic owner;
   logic bi;
   logic bd;

   assign busy  = (state != IDLE);
   assign done  = busy & (bus.mem_ack | tc);
   assign grant = (state == IDLE) & (bus.im_req | bus.dm_req);

   // Fetch wins a contested cycle only once data has used its streak.
   always_comb begin
      owner = OWNER_I;
      if (bus.dm_req && !(bus.im_req && streak == SMAX)) begin
         owner = OWNER_D;
      end
   end

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE),
      .en  (busy),
      .tc  (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         streak  <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant) begin
                  state <= busy_of(owner);
                  req_q <= 1'b1;
                  if (owner == OWNER_D) begin
                     addr_q  <= bus.dm_addr;
                     wr_q    <= bus.dm_write;
                     wdata_q <= bus.dm_wdata;
                     if (!bus.im_req) begin
                        streak <= '0;
                     end else if (streak != SMAX) begin
                        streak <= streak + 1'b1;
                     end
                  end else begin
                     addr_q  <= bus.im_addr;
                     wr_q    <= 1'b0;
                     wdata_q <= '0;
                     streak  <= '0;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (done) begin
                  state <= IDLE;
                  req_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   // A withdrawn fetch still finishes on memory but reports nothing.
   assign bi = ~rst & (state == BUSY_I) & bus.im_req;
   assign bd = ~rst & (state == BUSY_D);

   assign bus.im_valid = bi & (bus.mem_ack | tc);
   assign bus.im_err   = bi & tc & ~bus.mem_ack;
   assign bus.im_data  = (bi & bus.mem_ack) ? bus.mem_read_data : '0;

   assign bus.dm_valid = bd & (bus.mem_ack | tc);
   assign bus.dm_err   = bd & tc & ~bus.mem_ack;
   assign bus.dm_rdata = (bd & bus.mem_ack) ? bus.mem_read_data : '0;

   assign bus.mem_req        = req_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_write      = wr_q;
   assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard
// and a programmable-latency memory responder.
module tb_mem_port_arbiter;

   typedef struct {
      bit          port;
      logic [31:0] data;
      bit          err;
   } exp_t;

   localparam logic [31:0] RD_OFS = 32'h0050_0053;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int v_cyc  = 0;
   int ack_lat = 0;
   int bcnt   = 0;
   int k      = 0;
   bit stray  = 1'b0;

   exp_t sb[$];
   exp_t mon_e;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(
      .AW              (32),
      .DW              (32),
      .MAX_DATA_STREAK (4),
      .TIMEOUT         (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(bit port, logic [31:0] d, bit err);
      exp_t e;
      e.port = port;
      e.data = d;
      e.err  = err;
      return e;
   endfunction

   // Memory: ack after ack_lat busy cycles (-1 = never); data = addr + RD_OFS.
   initial begin
      bus.mem_ack       = 1'b0;
      bus.mem_read_data = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.mem_req === 1'b1) begin
            bus.mem_ack = (ack_lat >= 0) && (bcnt == ack_lat);
            bcnt++;
         end else begin
            bus.mem_ack = stray;
            bcnt = 0;
         end
         bus.mem_read_data = bus.mem_addr + RD_OFS;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst && (bus.im_valid === 1'b1 || bus.dm_valid === 1'b1)) begin
         v_cyc = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_valid", {bus.im_valid, bus.dm_valid}, 2'b00);
         end else begin
            mon_e = sb.pop_front();
            chk("owner", bus.dm_valid, mon_e.port);
            chk("data", bus.dm_valid ? bus.dm_rdata : bus.im_data, mon_e.data);
            chk("err", bus.dm_valid ? bus.dm_err : bus.im_err, mon_e.err);
         end
      end
   end

   task automatic run_until_empty(string tag, int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_drain"}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic wait_mem_idle(string tag, int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.mem_req !== 1'b0 && n < budget);
      chk({tag, "_mem_idle"}, bus.mem_req, 0);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
      k = cyc;
   endtask

   initial begin
      bus.im_req   = 1'b1;
      bus.im_addr  = 32'h10;
      bus.dm_req   = 1'b1;
      bus.dm_addr  = 32'h20;
      bus.dm_write = 1'b0;
      bus.dm_wdata = '0;
      ack_lat      = 0;

      // 1. reset with both requests pending
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_mem_req", bus.mem_req, 0);
         chk("rst_im_valid", bus.im_valid, 0);
         chk("rst_dm_valid", bus.dm_valid, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_mem_wdata", bus.mem_write_data, 0);
      end
      @(posedge clk);
      #1;
      sb.push_back(mk(1'b1, 32'h20 + RD_OFS, 1'b0));
      rst = 1'b0;
      run_until_empty("rst_first_d", 20);
      bus.dm_req = 1'b0;
      sb.push_back(mk(1'b0, 32'h10 + RD_OFS, 1'b0));
      run_until_empty("rst_then_i", 20);
      bus.im_req = 1'b0;

      // 2. fetch only, ack in fourth busy cycle
      step();
      ack_lat     = 3;
      bus.im_addr = 32'h40;
      bus.im_req  = 1'b1;
      sb.push_back(mk(1'b0, 32'h0050_0093, 1'b0));
      @(negedge clk);
      chk("fetch_req_n", bus.mem_req, 0);
      @(negedge clk);
      chk("fetch_req_n1", bus.mem_req, 1);
      chk("fetch_addr", bus.mem_addr, 32'h40);
      chk("fetch_write", bus.mem_write, 0);
      run_until_empty("fetch", 20);
      bus.im_req = 1'b0;
      chk("fetch_lat", v_cyc - k, 4);

      // 3. store acked in first busy cycle
      step();
      ack_lat      = 0;
      bus.dm_addr  = 32'h100;
      bus.dm_wdata = 32'hDEAD_BEEF;
      bus.dm_write = 1'b1;
      bus.dm_req   = 1'b1;
      sb.push_back(mk(1'b1, 32'h100 + RD_OFS, 1'b0));
      @(negedge clk);
      @(negedge clk);
      chk("store_write", bus.mem_write, 1);
      chk("store_wdata", bus.mem_write_data, 32'hDEAD_BEEF);
      chk("store_addr", bus.mem_addr, 32'h100);
      run_until_empty("store", 20);
      bus.dm_req   = 1'b0;
      bus.dm_write = 1'b0;
      chk("store_lat", v_cyc - k, 1);

      // 4. starvation bound with both held
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ack_lat     = 1;
      bus.im_addr = 32'h80;
      bus.dm_addr = 32'h300;
      repeat (2) begin
         repeat (4) sb.push_back(mk(1'b1, 32'h300 + RD_OFS, 1'b0));
         sb.push_back(mk(1'b0, 32'h80 + RD_OFS, 1'b0));
      end
      bus.im_req = 1'b1;
      bus.dm_req = 1'b1;
      run_until_empty("streak", 100);
      bus.im_req = 1'b0;
      bus.dm_req = 1'b0;

      // 5. fetch flushed after grant
      step();
      ack_lat     = 2;
      bus.im_addr = 32'h44;
      bus.im_req  = 1'b1;
      step();
      bus.im_req = 1'b0;
      wait_mem_idle("flush", 20);
      bus.dm_addr = 32'h104;
      bus.dm_req  = 1'b1;
      sb.push_back(mk(1'b1, 32'h104 + RD_OFS, 1'b0));
      run_until_empty("after_flush", 20);
      bus.dm_req = 1'b0;

      // 6. timeout on a load
      step();
      ack_lat     = -1;
      bus.dm_addr = 32'h200;
      bus.dm_req  = 1'b1;
      sb.push_back(mk(1'b1, 32'h0, 1'b1));
      run_until_empty("timeout", 40);
      bus.dm_req = 1'b0;
      chk("timeout_lat", v_cyc - k, 16);
      @(negedge clk);
      chk("timeout_mem_req", bus.mem_req, 0);

      // 7. stray ack while idle
      step();
      stray = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_mem_req", bus.mem_req, 0);
         chk("stray_dm_valid", bus.dm_valid, 0);
      end
      step();
      stray = 1'b0;

      // 8. reset mid-transaction
      step();
      ack_lat     = -1;
      bus.im_addr = 32'h48;
      bus.im_req  = 1'b1;
      repeat (3) step();
      rst        = 1'b1;
      bus.im_req = 1'b0;
      @(negedge clk);
      chk("abort_im_valid", bus.im_valid, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_mem_req", bus.mem_req, 0);
      repeat (3) @(negedge clk);
      chk("final_sb", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
